// File: rtl/spike_aer_encoder_pkg.sv
// Shared types for the spike-to-AER encoder: output handshake states and the event record.
// Both record fields are sized for the largest legal configuration; narrower instances leave the upper bits zero.
package spike_aer_encoder_pkg;

    localparam int unsigned AER_ADDR_W_MAX = 3;
    localparam int unsigned AER_TS_W_MAX   = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } aer_state_e;

    typedef struct packed {
        logic [AER_ADDR_W_MAX-1:0] addr;
        logic [AER_TS_W_MAX-1:0]   ts;
    } aer_event_t;

    // Index of the lowest set bit; returns 0 when no bit is set.
    function automatic logic [AER_ADDR_W_MAX-1:0] lowest_set(input logic [7:0] v);
        logic [AER_ADDR_W_MAX-1:0] idx;
        logic                      found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i] && !found) begin
                idx   = AER_ADDR_W_MAX'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// Event FIFO for the AER encoder: power-of-two depth, wrapping pointers.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module aer_event_fifo
    import spike_aer_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  aer_event_t               data_i,
    input  logic                     pop_i,
    output aer_event_t               data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    aer_event_t      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        full_o   = (count_q == (PW+1)'(DEPTH));
        empty_o  = (count_q == '0);
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= (PW+1)'(DEPTH));

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike-to-AER encoder: captures one-cycle spikes with a timestamp, arbitrates them
// lowest-channel-first into an event FIFO, and presents events on a 4-phase req/ack link.
module spike_aer_encoder
    import spike_aer_encoder_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TS_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [N_CH-1:0]            spike_in,
    output logic                       aer_req,
    input  logic                       aer_ack,
    output logic [$clog2(N_CH)-1:0]    aer_addr,
    output logic [TS_W-1:0]            aer_ts,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam int unsigned AW = $clog2(N_CH);

    logic [TS_W-1:0]            ts_q, ts_d;
    logic [N_CH-1:0]            pending_q, pending_d;
    logic [TS_W-1:0]            stamp_q [N_CH];
    logic [TS_W-1:0]            stamp_d [N_CH];
    logic                       overflow_q, overflow_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [TS_W-1:0]            ts_out_q, ts_out_d;
    aer_state_e                 state_q, state_d;

    logic [AER_ADDR_W_MAX-1:0]  win_idx;
    logic [TS_W-1:0]            win_ts;
    logic [N_CH-1:0]            grant;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       head_load;
    aer_event_t                 push_evt;
    aer_event_t                 head_evt;
    logic                       unused_head;

    // Arbiter: at most one grant per cycle; a full FIFO still takes it when popping.
    always_comb begin
        win_idx   = lowest_set(8'(pending_q));
        fifo_push = ena && (|pending_q) && (!fifo_full || fifo_pop);
        grant     = '0;
        win_ts    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (fifo_push && (win_idx == AER_ADDR_W_MAX'(i))) begin
                grant[i] = 1'b1;
                win_ts   = stamp_q[i];
            end
        end
        push_evt.addr = win_idx;
        push_evt.ts   = AER_TS_W_MAX'(win_ts);
    end

    // A spike re-arms a channel only when its slot is free or being granted this cycle.
    always_comb begin
        ts_d       = ena ? ts_q + 1'b1 : ts_q;
        pending_d  = pending_q & ~grant;
        stamp_d    = stamp_q;
        overflow_d = overflow_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ena && spike_in[i]) begin
                if (!pending_q[i] || grant[i]) begin
                    pending_d[i] = 1'b1;
                    stamp_d[i]   = ts_q;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q       <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                stamp_q[i] <= '0;
            end
        end else begin
            ts_q       <= ts_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            stamp_q    <= stamp_d;
        end
    end

    aer_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  (push_evt),
        .pop_i   (fifo_pop),
        .data_o  (head_evt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                ST_IDLE:     if (!fifo_empty && !aer_ack) state_d = ST_REQ;
                ST_REQ:      if (aer_ack)                 state_d = ST_WAIT_LOW;
                ST_WAIT_LOW: if (!aer_ack)                state_d = ST_IDLE;
                default:                                  state_d = ST_IDLE;
            endcase
        end
    end

    // The head stays in the FIFO while presented and is popped on the acknowledge edge.
    always_comb begin
        aer_req   = (state_q == ST_REQ);
        fifo_pop  = ena && (state_q == ST_REQ) && aer_ack;
        head_load = ena && (state_q == ST_IDLE) && !fifo_empty && !aer_ack;
        addr_d    = head_load ? head_evt.addr[AW-1:0] : addr_q;
        ts_out_d  = head_load ? head_evt.ts[TS_W-1:0] : ts_out_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q   <= '0;
            ts_out_q <= '0;
        end else begin
            addr_q   <= addr_d;
            ts_out_q <= ts_out_d;
        end
    end

    assign aer_addr    = addr_q;
    assign aer_ts      = ts_out_q;
    assign overflow    = overflow_q;
    assign unused_head = ^head_evt;

    a_event_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (aer_req && !aer_ack) |=> ($stable(aer_addr) && $stable(aer_ts)));

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Self-checking bench for spike_aer_encoder: table-driven enable/latency vectors,
// hand-written corner sequences, and a scoreboard of expected events checked on each request.
module tb_spike_aer_encoder;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TS_W  = 4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ena      = 1'b0;
    logic [3:0] spike_in = '0;
    logic       aer_ack  = 1'b0;
    logic       aer_req;
    logic [1:0] aer_addr;
    logic [3:0] aer_ts;
    logic [2:0] fifo_count;
    logic       overflow;

    spike_aer_encoder #(
        .N_CH  (N_CH),
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .spike_in   (spike_in),
        .aer_req    (aer_req),
        .aer_ack    (aer_ack),
        .aer_addr   (aer_addr),
        .aer_ts     (aer_ts),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] addr;
        logic [3:0] ts;
    } evt_t;

    typedef struct {
        logic       ena;
        logic [3:0] spk;
        logic       exp_req;
        logic [2:0] exp_cnt;
        logic [1:0] exp_addr;
        logic [3:0] exp_ts;
    } row_t;

    evt_t       sb[$];
    evt_t       mon_e;
    row_t       tbl [9];
    int         n_tests  = 0;
    int         n_fail   = 0;
    logic [3:0] tb_ts    = '0;
    logic       ack_auto = 1'b1;
    logic       ack_hold = 1'b0;
    logic       prev_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Consumer: compares each newly raised request against the scoreboard, then drives ack.
    always @(negedge clk) begin
        if (aer_req && !prev_req) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: got addr %0d ts %0d, expected no event", aer_addr, aer_ts);
            end else begin
                mon_e = sb.pop_front();
                chk("evt_addr", 32'(aer_addr), 32'(mon_e.addr));
                chk("evt_ts", 32'(aer_ts), 32'(mon_e.ts));
            end
        end
        prev_req = aer_req;
        aer_ack  = ack_auto ? aer_req : ack_hold;
    end

    task automatic step();
        logic was_rst;
        logic adv;
        was_rst = !rst_n;
        adv     = rst_n && ena;
        @(posedge clk);
        #1;
        if (was_rst)  tb_ts = '0;
        else if (adv) tb_ts = tb_ts + 1'b1;
    endtask

    task automatic push_exp(input logic [1:0] a, input logic [3:0] t);
        evt_t e;
        e.addr = a;
        e.ts   = t;
        sb.push_back(e);
    endtask

    // Isolated spikes on an idle channel each become one event stamped with the current cycle.
    task automatic drive(input logic [3:0] spk, input logic model);
        spike_in = spk;
        if (model && rst_n && ena) begin
            for (int i = 0; i < 4; i++) begin
                if (spk[i]) push_exp(2'(i), tb_ts);
            end
        end
    endtask

    task automatic drain(input string name);
        int unsigned n;
        n        = 0;
        ack_auto = 1'b1;
        spike_in = '0;
        while (!(sb.size() == 0 && !aer_req && !aer_ack && fifo_count == 0) && n < 200) begin
            step();
            n++;
        end
        chk({name, "_missing_events"}, 32'(sb.size()), 0);
        chk({name, "_fifo_empty"}, 32'(fifo_count), 0);
        repeat (4) step();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ena      = 1'b1;
        spike_in = '0;
        ack_auto = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        logic [3:0]  t0;
        int unsigned n;

        //            ena   spk      req   cnt   addr  ts
        tbl[0] = '{1'b0, 4'b0001, 1'b0, 3'd0, 2'd0, 4'd0};
        tbl[1] = '{1'b0, 4'b1111, 1'b0, 3'd0, 2'd0, 4'd0};
        tbl[2] = '{1'b1, 4'b0000, 1'b0, 3'd0, 2'd0, 4'd0};
        tbl[3] = '{1'b1, 4'b0010, 1'b0, 3'd0, 2'd0, 4'd0};
        tbl[4] = '{1'b1, 4'b0000, 1'b0, 3'd1, 2'd0, 4'd0};
        tbl[5] = '{1'b0, 4'b0000, 1'b0, 3'd1, 2'd0, 4'd0};
        tbl[6] = '{1'b0, 4'b0100, 1'b0, 3'd1, 2'd0, 4'd0};
        tbl[7] = '{1'b1, 4'b0000, 1'b1, 3'd1, 2'd1, 4'd1};
        tbl[8] = '{1'b1, 4'b0000, 1'b1, 3'd1, 2'd1, 4'd1};

        // Reset state
        do_reset();
        chk("rst_req", 32'(aer_req), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_addr", 32'(aer_addr), 0);
        chk("rst_ts", 32'(aer_ts), 0);

        // Single spike: request rises on the third edge after capture
        drive(4'b0001, 1'b1);
        step();
        chk("lat_edge1_req", 32'(aer_req), 0);
        drive(4'b0000, 1'b1);
        step();
        chk("lat_edge2_req", 32'(aer_req), 0);
        step();
        chk("lat_edge3_req", 32'(aer_req), 1);
        drain("single");

        // All channels at once: ascending addresses, shared stamp
        drive(4'b1111, 1'b1);
        step();
        drive(4'b0000, 1'b1);
        drain("burst");
        chk("burst_ovf", 32'(overflow), 0);

        // Enable gating vectors with ack held low
        do_reset();
        ack_auto = 1'b0;
        ack_hold = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ena = tbl[i].ena;
            drive(tbl[i].spk, 1'b1);
            step();
            chk($sformatf("row%0d_req", i), 32'(aer_req), 32'(tbl[i].exp_req));
            chk($sformatf("row%0d_count", i), 32'(fifo_count), 32'(tbl[i].exp_cnt));
            chk($sformatf("row%0d_addr", i), 32'(aer_addr), 32'(tbl[i].exp_addr));
            chk($sformatf("row%0d_ts", i), 32'(aer_ts), 32'(tbl[i].exp_ts));
            chk($sformatf("row%0d_ovf", i), 32'(overflow), 0);
        end
        drain("table");

        // Fill: ack low, channel 0 on six consecutive cycles; the sixth spike is dropped
        ena      = 1'b1;
        ack_auto = 1'b0;
        ack_hold = 1'b0;
        t0 = tb_ts;
        for (int k = 0; k < 5; k++) push_exp(2'd0, t0 + 4'(k));
        for (int k = 0; k < 6; k++) begin
            drive(4'b0001, 1'b0);
            step();
            if (k == 4) begin
                chk("fill_count_e4", 32'(fifo_count), 4);
                chk("fill_ovf_e4", 32'(overflow), 0);
            end
        end
        chk("fill_count", 32'(fifo_count), 4);
        chk("fill_ovf", 32'(overflow), 1);
        chk("fill_req", 32'(aer_req), 1);
        drive(4'b0000, 1'b0);
        ack_auto = 1'b1;
        step();
        chk("full_pushpop_count", 32'(fifo_count), 4);
        chk("full_pushpop_req", 32'(aer_req), 0);
        drain("fill");
        chk("ovf_sticky", 32'(overflow), 1);

        // Timestamp wrap: capture at 15, then two cycles later at 1
        n = 0;
        while (tb_ts != 4'd15 && n < 20) begin
            step();
            n++;
        end
        push_exp(2'd2, 4'd15);
        drive(4'b0100, 1'b0);
        step();
        drive(4'b0000, 1'b0);
        step();
        push_exp(2'd2, 4'd1);
        drive(4'b0100, 1'b0);
        step();
        drive(4'b0000, 1'b0);
        drain("wrap");

        // Reset during the handshake, ack held high across it
        ack_auto = 1'b0;
        ack_hold = 1'b0;
        drive(4'b0010, 1'b1);
        step();
        drive(4'b0000, 1'b1);
        step();
        step();
        chk("mid_req_before", 32'(aer_req), 1);
        ack_hold = 1'b1;
        rst_n    = 1'b0;
        step();
        chk("mid_rst_req", 32'(aer_req), 0);
        chk("mid_rst_count", 32'(fifo_count), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        sb.delete();
        drive(4'b1000, 1'b1);
        step();
        drive(4'b0000, 1'b1);
        step();
        chk("ackhi_count", 32'(fifo_count), 1);
        chk("ackhi_req_a", 32'(aer_req), 0);
        step();
        step();
        chk("ackhi_req_b", 32'(aer_req), 0);
        ack_hold = 1'b0;
        step();
        chk("acklo_req", 32'(aer_req), 1);
        drain("midreset");
        chk("final_ovf", 32'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
